// File: rtl/rx_frame_sequencer_if.sv
// Valid/ready stream bundle used for the frame input and the decoded-data output.
interface rx_frame_sequencer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rx_frame_sequencer.sv
// LiFi receive-chain control: sequences CRC decode then Hadamard/PAM receive
// for one frame at a time, drops CRC failures and hung stages, and keeps
// saturating status counters.
module rx_frame_sequencer #(
  parameter int unsigned INPUT_BITS      = 20,
  parameter int unsigned CRC_OUTPUT_BITS = INPUT_BITS - 4,
  parameter int unsigned OUT_BITS        = 6,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter int unsigned CNT_BITS        = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  rx_frame_sequencer_if.slave        in_if,
  output logic                       crc_start,
  output logic [INPUT_BITS-1:0]      crc_data,
  input  logic                       crc_done,
  input  logic                       crc_pass,
  input  logic [CRC_OUTPUT_BITS-1:0] crc_payload,
  output logic                       rx_en,
  output logic [CRC_OUTPUT_BITS-1:0] rx_data,
  input  logic                       rx_done,
  input  logic [OUT_BITS-1:0]        rx_result,
  rx_frame_sequencer_if.master       out_if,
  output logic [CNT_BITS-1:0]        frame_cnt,
  output logic [CNT_BITS-1:0]        crc_err_cnt,
  output logic [CNT_BITS-1:0]        timeout_cnt,
  output logic                       busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CRC_RUN  = 2'd1;
  localparam logic [1:0] RX_RUN   = 2'd2;
  localparam logic [1:0] OUT_HOLD = 2'd3;

  localparam int unsigned TMR_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT_CYCLES - 1);

  logic [1:0]          state;
  logic [TMR_BITS-1:0] timer;
  logic [OUT_BITS-1:0] out_data_q;
  logic                expired;

  // Stage run levels and handshakes are pure state decodes, so no input reaches an output.
  always_comb begin
    in_if.ready  = (state == IDLE);
    crc_start    = (state == CRC_RUN);
    rx_en        = (state == RX_RUN);
    out_if.valid = (state == OUT_HOLD);
    out_if.data  = out_data_q;
    busy         = (state != IDLE);
    expired      = (timer == TMR_LAST);
  end

  // Frame sequencing, stage timer and saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      crc_data    <= '0;
      rx_data     <= '0;
      out_data_q  <= '0;
      frame_cnt   <= '0;
      crc_err_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_if.valid) begin
            crc_data <= in_if.data;
            timer    <= '0;
            state    <= CRC_RUN;
          end
        end
        CRC_RUN: begin
          // A done on the expiry cycle takes priority over the timeout.
          if (crc_done) begin
            if (crc_pass) begin
              rx_data <= crc_payload;
              timer   <= '0;
              state   <= RX_RUN;
            end else begin
              if (crc_err_cnt != '1) crc_err_cnt <= crc_err_cnt + 1'b1;
              state <= IDLE;
            end
          end else if (expired) begin
            if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_RUN: begin
          if (rx_done) begin
            out_data_q <= rx_result;
            state      <= OUT_HOLD;
          end else if (expired) begin
            if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        OUT_HOLD: begin
          if (out_if.ready) begin
            if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed bench for rx_frame_sequencer (CNT_BITS=4 so saturation is reachable).
module tb_rx_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        crc_start;
  logic [19:0] crc_data;
  logic        crc_done;
  logic        crc_pass;
  logic [15:0] crc_payload;
  logic        rx_en;
  logic [15:0] rx_data;
  logic        rx_done;
  logic [5:0]  rx_result;
  logic [3:0]  frame_cnt;
  logic [3:0]  crc_err_cnt;
  logic [3:0]  timeout_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int overlap = 0;
  int accepts = 0;

  rx_frame_sequencer_if #(.WIDTH(20)) in_if ();
  rx_frame_sequencer_if #(.WIDTH(6))  out_if ();

  rx_frame_sequencer #(
    .INPUT_BITS(20), .CRC_OUTPUT_BITS(16), .OUT_BITS(6),
    .TIMEOUT_CYCLES(64), .CNT_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .in_if(in_if),
    .crc_start(crc_start), .crc_data(crc_data), .crc_done(crc_done),
    .crc_pass(crc_pass), .crc_payload(crc_payload),
    .rx_en(rx_en), .rx_data(rx_data), .rx_done(rx_done), .rx_result(rx_result),
    .out_if(out_if), .frame_cnt(frame_cnt), .crc_err_cnt(crc_err_cnt),
    .timeout_cnt(timeout_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observe stage overlap and accepted output beats on the inactive edge.
  always @(negedge clk) begin
    if (crc_start && rx_en) overlap++;
    if (out_if.valid && out_if.ready) accepts++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b1;
    crc_done = 1'b0; crc_pass = 1'b0; crc_payload = '0;
    rx_done = 1'b0; rx_result = '0;
    #1;
    checks++;
    if ({in_if.ready, crc_start, rx_en, out_if.valid, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 10000", {in_if.ready, crc_start, rx_en, out_if.valid, busy});
    end
    checks++;
    if ({frame_cnt, crc_err_cnt, timeout_cnt, out_if.data} !== 18'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h expected 0", {frame_cnt, crc_err_cnt, timeout_cnt, out_if.data});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int acc0;
    acc0 = accepts;
    in_if.valid = 1'b1; in_if.data = 20'hA5F3C;
    tick();
    in_if.valid = 1'b0;
    checks++;
    if ({crc_start, in_if.ready, crc_data} !== {2'b10, 20'hA5F3C}) begin
      errors++;
      $display("FAIL nom_crc_run: got %b %b %h expected 1 0 a5f3c", crc_start, in_if.ready, crc_data);
    end
    tick(); tick();
    crc_done = 1'b1; crc_pass = 1'b1; crc_payload = 16'hA5F3;
    tick();
    crc_done = 1'b0; crc_pass = 1'b0;
    checks++;
    if ({rx_en, crc_start, rx_data} !== {2'b10, 16'hA5F3}) begin
      errors++;
      $display("FAIL nom_rx_run: got %b %b %h expected 1 0 a5f3", rx_en, crc_start, rx_data);
    end
    tick(); tick(); tick();
    rx_done = 1'b1; rx_result = 6'h2B;
    tick();
    rx_done = 1'b0; rx_result = 6'h00;
    checks++;
    if ({out_if.valid, out_if.data} !== {1'b1, 6'h2B}) begin
      errors++;
      $display("FAIL nom_out: got %b %h expected 1 2b", out_if.valid, out_if.data);
    end
    tick();
    checks++;
    if ({out_if.valid, in_if.ready, frame_cnt} !== {2'b01, 4'd1}) begin
      errors++;
      $display("FAIL nom_done: got %b %b %0d expected 0 1 1", out_if.valid, in_if.ready, frame_cnt);
    end
    checks++;
    if (accepts - acc0 !== 1) begin
      errors++;
      $display("FAIL nom_beats: got %0d expected 1", accepts - acc0);
    end
  endtask

  task automatic test_crc_fail();
    in_if.valid = 1'b1; in_if.data = 20'h12345;
    tick();
    in_if.valid = 1'b0;
    crc_done = 1'b1; crc_pass = 1'b0;
    tick();
    crc_done = 1'b0;
    checks++;
    if ({in_if.ready, rx_en, out_if.valid, crc_err_cnt} !== {3'b100, 4'd1}) begin
      errors++;
      $display("FAIL crc_fail: got %b %b %b %0d expected 1 0 0 1", in_if.ready, rx_en, out_if.valid, crc_err_cnt);
    end
    // Stray dones while idle must not move the FSM.
    crc_done = 1'b1; crc_pass = 1'b1; rx_done = 1'b1;
    tick();
    crc_done = 1'b0; crc_pass = 1'b0; rx_done = 1'b0;
    checks++;
    if ({busy, crc_err_cnt, frame_cnt} !== {1'b0, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL idle_ignore: got %b %0d %0d expected 0 1 1", busy, crc_err_cnt, frame_cnt);
    end
  endtask

  task automatic test_timeout_crc();
    int n;
    in_if.valid = 1'b1; in_if.data = 20'h0BEEF;
    tick();
    in_if.valid = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (!crc_start) break;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL to_crc_cycles: got %0d expected 64", n);
    end
    checks++;
    if ({in_if.ready, crc_start, timeout_cnt} !== {2'b10, 4'd1}) begin
      errors++;
      $display("FAIL to_crc_state: got %b %b %0d expected 1 0 1", in_if.ready, crc_start, timeout_cnt);
    end
  endtask

  task automatic test_timeout_rx();
    int n;
    in_if.valid = 1'b1; in_if.data = 20'h0CAFE;
    tick();
    in_if.valid = 1'b0;
    crc_done = 1'b1; crc_pass = 1'b1; crc_payload = 16'h0CAF;
    tick();
    crc_done = 1'b0; crc_pass = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (!rx_en) break;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL to_rx_cycles: got %0d expected 64", n);
    end
    checks++;
    if ({in_if.ready, out_if.valid, timeout_cnt} !== {2'b10, 4'd2}) begin
      errors++;
      $display("FAIL to_rx_state: got %b %b %0d expected 1 0 2", in_if.ready, out_if.valid, timeout_cnt);
    end
  endtask

  task automatic test_done_at_expiry();
    in_if.valid = 1'b1; in_if.data = 20'h55AA5;
    tick();
    in_if.valid = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    crc_done = 1'b1; crc_pass = 1'b1; crc_payload = 16'h55AA;
    tick();
    crc_done = 1'b0; crc_pass = 1'b0;
    checks++;
    if ({rx_en, timeout_cnt} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL done_wins: got %b %0d expected 1 2", rx_en, timeout_cnt);
    end
    rx_done = 1'b1; rx_result = 6'h11;
    tick();
    rx_done = 1'b0;
    tick();
    checks++;
    if ({in_if.ready, frame_cnt} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL done_wins_frame: got %b %0d expected 1 2", in_if.ready, frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    out_if.ready = 1'b0;
    in_if.valid = 1'b1; in_if.data = 20'h77777;
    tick();
    in_if.valid = 1'b0;
    crc_done = 1'b1; crc_pass = 1'b1; crc_payload = 16'h7777;
    tick();
    crc_done = 1'b0; crc_pass = 1'b0;
    rx_done = 1'b1; rx_result = 6'h15;
    tick();
    rx_done = 1'b0; rx_result = 6'h3F;
    bad = 0;
    in_if.valid = 1'b1; in_if.data = 20'hDEAD0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({out_if.valid, out_if.data, in_if.ready, frame_cnt} !== {1'b1, 6'h15, 1'b0, 4'd2}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles expected 0", bad);
    end
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    tick();
    checks++;
    if ({out_if.valid, frame_cnt, crc_data} !== {1'b0, 4'd3, 20'h77777}) begin
      errors++;
      $display("FAIL bp_release: got %b %0d %h expected 0 3 77777", out_if.valid, frame_cnt, crc_data);
    end
  endtask

  task automatic test_reset_mid();
    in_if.valid = 1'b1; in_if.data = 20'h13579;
    tick();
    in_if.valid = 1'b0;
    crc_done = 1'b1; crc_pass = 1'b1; crc_payload = 16'h1357;
    tick();
    crc_done = 1'b0; crc_pass = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rx_en, out_if.valid, in_if.ready, frame_cnt, crc_err_cnt, timeout_cnt} !== {3'b001, 12'h000}) begin
      errors++;
      $display("FAIL async_reset: got %b %b %b %h %h %h expected 0 0 1 0 0 0",
               rx_en, out_if.valid, in_if.ready, frame_cnt, crc_err_cnt, timeout_cnt);
    end
    tick();
    reset = 1'b0;
    tick();
    in_if.valid = 1'b1; in_if.data = 20'h2468A;
    tick();
    in_if.valid = 1'b0;
    crc_done = 1'b1; crc_pass = 1'b1; crc_payload = 16'h2468;
    tick();
    crc_done = 1'b0; crc_pass = 1'b0;
    rx_done = 1'b1; rx_result = 6'h2A;
    tick();
    rx_done = 1'b0;
    checks++;
    if ({out_if.valid, out_if.data, rx_data} !== {1'b1, 6'h2A, 16'h2468}) begin
      errors++;
      $display("FAIL post_reset_out: got %b %h %h expected 1 2a 2468", out_if.valid, out_if.data, rx_data);
    end
    tick();
    checks++;
    if (frame_cnt !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 17; i++) begin
      in_if.valid = 1'b1; in_if.data = 20'(i);
      tick();
      in_if.valid = 1'b0;
      crc_done = 1'b1; crc_pass = 1'b0;
      tick();
      crc_done = 1'b0;
      if (i == 14) begin
        checks++;
        if (crc_err_cnt !== 4'hE) begin
          errors++;
          $display("FAIL sat_count14: got %h expected e", crc_err_cnt);
        end
      end
    end
    checks++;
    if ({crc_err_cnt, frame_cnt, timeout_cnt} !== {4'hF, 4'd1, 4'd0}) begin
      errors++;
      $display("FAIL sat_hold: got %h %h %h expected f 1 0", crc_err_cnt, frame_cnt, timeout_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_crc_fail();
    test_timeout_crc();
    test_timeout_rx();
    test_done_at_expiry();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL stage_overlap: got %0d cycles expected 0", overlap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
